// File: rtl/tau_pkg.sv
// tau_pkg: shared state encoding, default widths and the shifted-term helper for the tau MAC
package tau_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, OUT} tau_state_e;

    localparam int TAU_WIDTH     = 8;
    localparam int TAU_ACC_WIDTH = 2 * TAU_WIDTH + 8;
    localparam int TAU_MAX_W     = 256;

    function automatic logic [TAU_MAX_W-1:0] tau_term(input logic [TAU_MAX_W-1:0] b, input int unsigned k);
        return b << k;
    endfunction

endpackage

// File: rtl/tau_msb_encoder.sv
// tau_msb_encoder: MSB index, one-hot of the MSB and at-most-one-bit detection for a vector
module tau_msb_encoder
    import tau_pkg::*;
#(
    parameter int WIDTH = TAU_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [WIDTH-1:0] onehot,
    output logic             single
);

    // highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (vec[i]) idx = IDX_W'(i);
    end

    assign any    = |vec;
    assign onehot = any ? (WIDTH'(1) << idx) : '0;
    assign single = (vec & (vec - WIDTH'(1))) == '0;

endmodule

// File: rtl/tau_mac_stream.sv
// tau_mac_stream: streaming tau-encoded MAC, one add per set bit of a, result on valid/ready
module tau_mac_stream
    import tau_pkg::*;
#(
    parameter int WIDTH     = TAU_WIDTH,
    parameter int ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int IDX_W = $clog2(WIDTH);

    tau_state_e           state_q;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q;
    logic                 ovf_q, ovf_d, out_ovf_q, last_q;
    logic [WIDTH-1:0]     a_rem_q, b_q, enc_onehot;
    logic [IDX_W-1:0]     enc_idx;
    logic                 enc_any, enc_single;
    logic [ACC_WIDTH:0]   sum;

    tau_msb_encoder #(.WIDTH(WIDTH)) u_enc (
        .vec    (a_rem_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .onehot (enc_onehot),
        .single (enc_single)
    );

    // accumulator after this cycle's add; an empty a_rem leaves it untouched
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(tau_term(TAU_MAX_W'(b_q), 32'(enc_idx)))};
        acc_d = enc_any ? sum[ACC_WIDTH-1:0] : acc_q;
        ovf_d = ovf_q | (enc_any & sum[ACC_WIDTH]);
    end

    // control FSM with accumulator, operand and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            a_rem_q    <= '0;
            b_q        <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    if (in_valid) begin
                        a_rem_q <= in_a;
                        b_q     <= in_b;
                        last_q  <= in_last;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    a_rem_q <= a_rem_q & ~enc_onehot;
                    if (enc_single && last_q) begin
                        out_data_q <= acc_d;
                        out_ovf_q  <= ovf_d;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        state_q    <= OUT;
                    end else begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        if (enc_single) state_q <= IDLE;
                    end
                end
                OUT: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_tau_mac_stream.sv
// tb_tau_mac_stream: randomized scoreboard bench against a product-sum reference model
module tb_tau_mac_stream;

    localparam int W  = 8;
    localparam int AW = 16;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid, out_ovf;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [AW-1:0] out_data, held;
    logic [AW:0]   e;
    logic [AW:0]   exp_q[$];
    longint unsigned total = 0;
    int checks = 0, failures = 0, rdy_mode = 1, seen;

    always #5 clk = ~clk;

    tau_mac_stream #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[AW-1:0]);
                chk("out_ovf", out_ovf, e[AW]);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last, input logic clr = 1'b0);
        int n;
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_a = a; in_b = b; in_last = last; clear = clr; in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept");
            in_valid = 1'b0;
            clear = 1'b0;
            return;
        end
        if (clr) total = 0;
        total += longint'(a) * longint'(b);
        if (last) begin
            exp_q.push_back({(total >= 64'(2 ** AW)), AW'(total % 64'(2 ** AW))});
            total = 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        n = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready || out_valid) break;
            n++;
        end
        chk("busy_cycles", n, ($countones(a) > 0) ? $countones(a) : 1);
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        send(8'h0B, 8'd3, 1'b1);
        send(8'h00, 8'hFF, 1'b1);
        send(8'd2, 8'd5, 1'b0);
        send(8'd3, 8'd7, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'd1, 8'd1, 1'b1);

        rdy_mode = 0;
        send(8'd5, 8'd6, 1'b1);
        held = out_data;
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, held);
            chk("hold_in_ready", in_ready, 0);
        end
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);

        send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'd1, 8'd1, 1'b1);

        @(posedge clk);
        #1;
        in_a = 8'hFF; in_b = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("pre_reset_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        total = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("no_out_after_reset", seen, 0);
        chk("idle_after_reset", in_ready, 1);
        send(8'd4, 8'd4, 1'b1);
        send(8'd10, 8'd10, 1'b0);
        send(8'd1, 8'd9, 1'b1, 1'b1);

        rdy_mode = 2;
        for (int i = 0; i < 40; i++)
            send(W'($urandom), W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        send(W'($urandom), W'($urandom), 1'b1);
        rdy_mode = 1;
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
